uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one UART transmitter (9600 baud, 10416 clocks per bit at 100 MHz) among NREQ byte-stream requesters. A requester holds the transmitter for a whole packet, from its first byte until it marks a byte as last. The arbiter sequences each byte into the transmitter with a start/busy handshake and enforces an idle gap on the line between packets. It sits between the command/telemetry sources and the UART TX datapath, mirroring the RX side.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arb_if.sv | 24 ++
 rtl/uart_tx_arb_rr_pick.sv | 29 ++
 rtl/uart_tx_arb.sv | 123 ++++++++++++
 tb/tb_uart_tx_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encodings and baud timing constants
// common to the TX arbiter, the transmitter and uartrx_simple.
package uart_pkg;

  localparam int unsigned CLK_PERIOD = 10;     // ns, 100 MHz system clock
  localparam int unsigned BAUD_MULT  = 10416;  // clocks per bit at 9600 baud

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams plus the transmitter start/busy handshake shared by uart_tx_arb.
interface uart_tx_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] din;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  // master: requesters and transmitter; slave: the arbiter
  modport master (
    output req, din, last, tx_busy,
    input  ack, gnt, tx_start, tx_data
  );

  modport slave (
    input  req, din, last, tx_busy,
    output ack, gnt, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin pick: first requester after ptr (wrapping), as one-hot and index.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!valid && req[IW'(cand)]) begin
        valid            = 1'b1;
        idx              = IW'(cand);
        gnt[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one UART transmitter, with an idle gap after each packet.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned GAP_CLKS = BAUD_MULT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  uart_tx_arb_if.slave       bus,
  output logic [2:0]         out_state
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (GAP_CLKS == 0) ? 1 : $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CLKS == 0) ? '0 : CW'(GAP_CLKS - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
  logic [IW-1:0]     gidx_q, gidx_d, ptr_q, ptr_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= IW'(NREQ - 1);
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  // ptr only moves at packet end (completed or abandoned), which is what keeps the rotation fair
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_valid) begin
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.req[gidx_q]) begin
          tx_data_d  = bus.din[{gidx_q, 3'b000} +: 8];
          last_d     = bus.last[gidx_q];
          tx_start_d = 1'b1;
          ack_d      = gnt_q;
          state_d    = ST_START;
        end else begin
          gnt_d   = '0;
          ptr_d   = gidx_q;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            gnt_d   = '0;
            ptr_d   = gidx_q;
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (GAP_CLKS == 0 || cnt_q == GAP_LAST) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign out_state    = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester byte-stream models, a busy-timed transmitter model,
// a table of arbitration vectors and hand-written multi-cycle sequences.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 8;
  localparam int unsigned BUSY = 12;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [2:0] out_state;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .GAP_CLKS(GAP)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .bus       (bus),
    .out_state (out_state)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Requester streams: bytes [s_sent..s_end) are pending; ack advances s_sent
  logic [7:0]      sdata [NREQ][32];
  logic            slast [NREQ][32];
  int unsigned     s_end [NREQ];
  int unsigned     s_sent[NREQ];
  logic [NREQ-1:0] drop;

  initial for (int i = 0; i < NREQ; i++) s_sent[i] = 0;

  always @(posedge clk)
    for (int i = 0; i < NREQ; i++)
      if (bus.ack[i]) s_sent[i] <= s_sent[i] + 1;

  always_comb begin
    bus.req  = '0;
    bus.din  = '0;
    bus.last = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]       = !drop[i] && (s_sent[i] < s_end[i]);
      bus.din[8*i +: 8] = sdata[i][s_sent[i] % 32];
      bus.last[i]      = slast[i][s_sent[i] % 32];
    end
  end

  // Transmitter model: busy for BUSY cycles starting the cycle after tx_start
  logic        busy;
  int unsigned bcnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (bus.tx_start) begin
      busy <= 1'b1;
      bcnt <= BUSY - 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else begin
      busy <= 1'b0;
    end
  end
  assign bus.tx_busy = busy;

  // Monitor: log every transmitted byte and every change of gnt
  logic [7:0]  log_data[64];
  logic [3:0]  log_gnt [64];
  int unsigned log_cyc [64];
  int unsigned log_n = 0;
  int unsigned cyc = 0;
  logic [3:0]  hist[128];
  int unsigned hist_n = 0;
  logic [3:0]  prev_gnt = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_start && log_n < 64) begin
      log_data[log_n] <= bus.tx_data;
      log_gnt[log_n]  <= bus.gnt;
      log_cyc[log_n]  <= cyc;
      log_n           <= log_n + 1;
    end
    if (bus.gnt != prev_gnt && hist_n < 128) begin
      hist[hist_n] <= bus.gnt;
      hist_n       <= hist_n + 1;
    end
    prev_gnt <= bus.gnt;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    sdata[i][s_end[i] % 32] = b;
    slast[i][s_end[i] % 32] = l;
    s_end[i]++;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int unsigned k;
    k = 0;
    while (out_state !== s && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, out_state, s);
  endtask

  task automatic wait_log(input int unsigned target, input string name);
    int unsigned k;
    k = 0;
    while (log_n < target && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 32'(log_n >= target), 1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    int unsigned n;
    int unsigned ord[4];
  } vec_t;

  function automatic vec_t mk(input logic [3:0] m, input int unsigned n,
                              input int unsigned o0, o1, o2, o3);
    vec_t v;
    v.mask = m; v.n = n;
    v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2; v.ord[3] = o3;
    return v;
  endfunction

  vec_t        vt[8];
  int unsigned base, h0, gcount;
  logic [3:0]  one;

  initial begin
    nrst = 1'b0;
    en   = 1'b1;
    drop = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_end[i] = 0;
      for (int k = 0; k < 32; k++) begin
        sdata[i][k] = '0;
        slast[i][k] = 1'b0;
      end
    end

    // ptr starts at 3; all requesters in a vector are raised together with one-byte packets
    vt[0] = mk(4'b0001, 1, 0, 0, 0, 0);
    vt[1] = mk(4'b1111, 4, 1, 2, 3, 0);
    vt[2] = mk(4'b0110, 2, 1, 2, 0, 0);
    vt[3] = mk(4'b1011, 3, 3, 0, 1, 0);
    vt[4] = mk(4'b0101, 2, 2, 0, 0, 0);
    vt[5] = mk(4'b1000, 1, 3, 0, 0, 0);
    vt[6] = mk(4'b1001, 2, 0, 3, 0, 0);
    vt[7] = mk(4'b0011, 2, 0, 1, 0, 0);

    // Reset values, sampled while reset is held
    #3;
    check("rst_gnt", bus.gnt, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_state", out_state, 0);
    do_reset();
    repeat (3) @(posedge clk);
    #1 check("idle_no_req_gnt", bus.gnt, 0);

    // Table-driven arbitration order
    for (int v = 0; v < 8; v++) begin
      base = log_n;
      for (int i = 0; i < NREQ; i++)
        if (vt[v].mask[i]) push(i, 8'((v << 4) | i), 1'b1);
      wait_log(base + vt[v].n, $sformatf("vec%0d_done", v));
      wait_state(ST_GAP, $sformatf("vec%0d_gap", v));
      wait_state(ST_IDLE, $sformatf("vec%0d_idle", v));
      for (int k = 0; k < int'(vt[v].n); k++) begin
        one = 4'b0001 << vt[v].ord[k];
        check($sformatf("vec%0d_gnt%0d", v, k), log_gnt[base + k], one);
        check($sformatf("vec%0d_data%0d", v, k), log_data[base + k], (v << 4) | vt[v].ord[k]);
      end
    end

    // Single byte: latency, handshake and gap length
    do_reset();
    base = log_n;
    push(0, 8'h45, 1'b1);
    @(posedge clk); #1;
    check("s1_gnt", bus.gnt, 4'b0001);
    check("s1_load", out_state, ST_LOAD);
    @(posedge clk); #1;
    check("s1_start", bus.tx_start, 1);
    check("s1_ack", bus.ack, 4'b0001);
    check("s1_data", bus.tx_data, 8'h45);
    @(posedge clk); #1;
    check("s1_start_pulse", bus.tx_start, 0);
    check("s1_wait", out_state, ST_WAIT);
    repeat (4) @(posedge clk);
    #1 check("s1_gnt_busy", bus.gnt, 4'b0001);
    wait_state(ST_GAP, "s1_gap");
    check("s1_gap_gnt", bus.gnt, 0);
    gcount = 1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (out_state != ST_GAP) break;
      gcount++;
    end
    check("s1_gap_len", gcount, GAP);
    check("s1_after_gap", out_state, ST_IDLE);
    check("s1_one_byte", log_n, base + 1);

    // Two simultaneous multi-byte packets: no interleave, gap between packets
    do_reset();
    base = log_n;
    h0 = hist_n;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b1);
    push(1, 8'h33, 1'b0); push(1, 8'h44, 1'b1);
    wait_log(base + 4, "s2_done");
    wait_state(ST_GAP, "s2_gap");
    wait_state(ST_IDLE, "s2_idle");
    check("s2_b0", log_data[base], 8'h11);
    check("s2_b1", log_data[base + 1], 8'h22);
    check("s2_b2", log_data[base + 2], 8'h33);
    check("s2_b3", log_data[base + 3], 8'h44);
    check("s2_byte_gap", log_cyc[base + 1] - log_cyc[base], BUSY + 3);
    check("s2_pkt_gap", log_cyc[base + 2] - log_cyc[base + 1], BUSY + GAP + 4);
    check("s2_byte_gap2", log_cyc[base + 3] - log_cyc[base + 2], BUSY + 3);
    check("s2_hist_n", hist_n - h0, 4);
    check("s2_hist0", hist[h0], 4'b0001);
    check("s2_hist1", hist[h0 + 1], 4'b0000);
    check("s2_hist2", hist[h0 + 2], 4'b0010);
    check("s2_hist3", hist[h0 + 3], 4'b0000);

    // Fairness: requesters 0 and 2 hold req across back-to-back one-byte packets
    do_reset();
    base = log_n;
    for (int k = 0; k < 3; k++) begin
      push(0, 8'(8'h80 + k), 1'b1);
      push(2, 8'(8'h90 + k), 1'b1);
    end
    wait_log(base + 6, "s3_done");
    wait_state(ST_GAP, "s3_gap");
    wait_state(ST_IDLE, "s3_idle");
    for (int k = 0; k < 6; k++) begin
      one = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      check($sformatf("s3_gnt%0d", k), log_gnt[base + k], one);
      check($sformatf("s3_data%0d", k), log_data[base + k],
            (k % 2 == 0) ? 8'h80 + k / 2 : 8'h90 + k / 2);
    end

    // Abandoned packet: req1 drops during WAIT of its first byte
    base = log_n;
    push(1, 8'h5A, 1'b0); push(1, 8'h5B, 1'b1);
    wait_log(base + 1, "s4_first");
    check("s4_data", log_data[base], 8'h5A);
    drop[1] = 1'b1;
    wait_state(ST_GAP, "s4_gap");
    check("s4_gap_gnt", bus.gnt, 0);
    wait_state(ST_IDLE, "s4_idle");
    repeat (5) @(posedge clk);
    #1 check("s4_no_second", log_n, base + 1);
    s_end[1] = s_sent[1];
    drop[1]  = 1'b0;

    // en low mid-packet: packet completes, pending req3 waits for en
    do_reset();
    base = log_n;
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
    wait_log(base + 1, "s5_first");
    en = 1'b0;
    push(3, 8'h74, 1'b1);
    wait_log(base + 3, "s5_all");
    wait_state(ST_GAP, "s5_gap");
    wait_state(ST_IDLE, "s5_idle");
    check("s5_b1", log_data[base + 1], 8'h72);
    check("s5_b2", log_data[base + 2], 8'h73);
    check("s5_b2_gnt", log_gnt[base + 2], 4'b0001);
    repeat (20) @(posedge clk);
    #1;
    check("s5_blocked_state", out_state, ST_IDLE);
    check("s5_blocked_gnt", bus.gnt, 0);
    en = 1'b1;
    @(posedge clk); #1;
    check("s5_req3_gnt", bus.gnt, 4'b1000);
    wait_log(base + 4, "s5_req3");
    check("s5_req3_data", log_data[base + 3], 8'h74);
    wait_state(ST_GAP, "s5_gap2");
    wait_state(ST_IDLE, "s5_idle2");

    // Asynchronous reset during WAIT
    do_reset();
    base = log_n;
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1);
    push(2, 8'h63, 1'b1);
    wait_log(base + 1, "s6_first");
    repeat (4) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("s6_gnt", bus.gnt, 0);
    check("s6_ack", bus.ack, 0);
    check("s6_tx_start", bus.tx_start, 0);
    check("s6_tx_data", bus.tx_data, 0);
    check("s6_state", out_state, 0);
    @(posedge clk); #1;
    check("s6_state_held", out_state, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("s6_regrant", bus.gnt, 4'b0001);
    wait_log(base + 2, "s6_second");
    check("s6_data", log_data[base + 1], 8'h62);
    wait_log(base + 3, "s6_third");
    check("s6_data2", log_data[base + 2], 8'h63);
    wait_state(ST_GAP, "s6_gap");
    wait_state(ST_IDLE, "s6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
